// File: rtl/dispatch_pkg.sv
// Shared types for the event dispatcher: the queued event record and its field widths.
package dispatch_pkg;

    localparam int WIDTH = 32;

    // "time" is a reserved word, so the stamp field is called ts.
    typedef struct packed {
        logic [3:0]       src;
        logic [WIDTH-1:0] ts;
        logic [WIDTH-1:0] value;
    } event_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle, searching from the
// index after the previous grant.
module rr_arbiter #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic             enable,
    output logic [N_SRC-1:0] grant
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = (idx == N_SRC - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/event_dispatcher.sv
// Captures time-stamped events from N_SRC sources into per-source slots, funnels them
// through a round-robin arbiter into a FIFO, and presents them on a valid/ready port.
module event_dispatcher #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 4,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              global_clock,
    input  logic [N_SRC-1:0]              send,
    input  logic [N_SRC-1:0][WIDTH-1:0]   data,
    input  logic                          clr_ovf,
    output logic                          out_valid,
    input  logic                          out_ready,
    output dispatch_pkg::event_t          out_event,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow
);

    import dispatch_pkg::event_t;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [N_SRC-1:0]            full_q, full_d;
    logic [N_SRC-1:0][WIDTH-1:0] ts_q, ts_d, val_q, val_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]               level_q, level_d;
    logic                        ovf_q, ovf_d;
    event_t                      fifo_q [DEPTH];

    logic [N_SRC-1:0] grant;
    logic             push, pop, push_ok, drop;
    event_t           push_event;

    // Handshake: an event moves to the consumer on every edge where out_valid and
    // out_ready are both high; out_ready alone has no effect.
    assign out_valid = (level_q != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = (level_q < LW'(DEPTH)) || pop;
    assign push      = |grant;

    rr_arbiter #(.N_SRC(N_SRC)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (full_q),
        .enable (push_ok),
        .grant  (grant)
    );

    always_comb begin
        push_event = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                push_event.src   = 4'(i);
                push_event.ts    = ts_q[i];
                push_event.value = val_q[i];
            end
        end
    end

    // A slot granted this cycle is free to take a new send on the same edge.
    always_comb begin
        full_d = full_q;
        ts_d   = ts_q;
        val_d  = val_q;
        drop   = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (send[i]) begin
                if (!full_q[i] || grant[i]) begin
                    full_d[i] = 1'b1;
                    ts_d[i]   = global_clock;
                    val_d[i]  = data[i];
                end else begin
                    drop = 1'b1;
                end
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q   <= '0;
            ts_q     <= '0;
            val_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            ts_q     <= ts_d;
            val_q    <= val_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_event;
    end

    assign out_event = fifo_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_event_dispatcher.sv
// Bench for event_dispatcher: directed vector table, hand sequences for back-pressure,
// reload and reset, then random traffic against a queue-based reference model.
module tb_event_dispatcher;

    import dispatch_pkg::*;

    localparam int N = 4;
    localparam int W = 32;
    localparam int D = 8;

    logic                clk;
    logic                rst;
    logic [W-1:0]        global_clock;
    logic [N-1:0]        send;
    logic [N-1:0][W-1:0] data;
    logic                clr_ovf;
    logic                out_valid;
    logic                out_ready;
    event_t              out_event;
    logic [3:0]          level;
    logic                overflow;

    int n_checks = 0;
    int n_fail   = 0;

    event_dispatcher #(.WIDTH(W), .N_SRC(N), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .global_clock (global_clock),
        .send         (send),
        .data         (data),
        .clr_ovf      (clr_ovf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_event    (out_event),
        .level        (level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending slots, an event queue and a round-robin start index.
    bit           m_pend [N];
    logic [W-1:0] m_ts   [N];
    logic [W-1:0] m_val  [N];
    event_t       m_q    [$];
    int           m_ptr;
    bit           m_ovf;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_q.delete();
        m_ptr = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] s, input logic [N-1:0][W-1:0] d,
                              input logic [W-1:0] gc, input logic rdy, input logic clr);
        bit     do_pop, can_push, dropped, found;
        int     g;
        event_t e;
        do_pop   = (m_q.size() != 0) && rdy;
        can_push = (m_q.size() < D) || do_pop;
        g        = -1;
        found    = 1'b0;
        if (can_push) begin
            for (int k = 0; k < N; k++) begin
                if (!found && m_pend[(m_ptr + k) % N]) begin
                    g     = (m_ptr + k) % N;
                    found = 1'b1;
                end
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (g >= 0) begin
            e.src   = 4'(g);
            e.ts    = m_ts[g];
            e.value = m_val[g];
            m_q.push_back(e);
            m_pend[g] = 1'b0;
            m_ptr     = (g + 1) % N;
        end
        dropped = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (s[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1'b1;
                    m_ts[i]   = gc;
                    m_val[i]  = d[i];
                end else begin
                    dropped = 1'b1;
                end
            end
        end
        if (dropped)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model_valid", 128'(out_valid), 128'(m_q.size() != 0));
        chk("model_level", 128'(level), 128'(m_q.size()));
        chk("model_ovf", 128'(overflow), 128'(m_ovf));
        if (m_q.size() != 0) chk("model_event", 128'(out_event), 128'(m_q[0]));
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks after the next rise.
    task automatic step(input logic [N-1:0] s, input logic [W-1:0] base,
                        input logic [W-1:0] gc, input logic rdy, input logic clr);
        send = s;
        for (int i = 0; i < N; i++) data[i] = base + W'(i);
        global_clock = gc;
        out_ready    = rdy;
        clr_ovf      = clr;
        @(posedge clk);
        model_edge(s, data, gc, rdy, clr);
        @(negedge clk);
        compare_model();
        send    = '0;
        clr_ovf = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] s;
        logic [W-1:0] base;
        logic [W-1:0] gc;
        logic         rdy;
        logic         exp_valid;
        logic [3:0]   exp_level;
        logic         exp_ovf;
        logic [3:0]   exp_src;
        logic [W-1:0] exp_ts;
        logic [W-1:0] exp_val;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Simultaneous sends from all four sources, then a single send on source 2.
        vecs[0] = '{4'b1111, 32'h10, 32'd200, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,   32'h0};
        vecs[1] = '{4'b0000, 32'h0,  32'd201, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 32'd200, 32'h10};
        vecs[2] = '{4'b0000, 32'h0,  32'd202, 1'b1, 1'b1, 4'd1, 1'b0, 4'd1, 32'd200, 32'h11};
        vecs[3] = '{4'b0000, 32'h0,  32'd203, 1'b1, 1'b1, 4'd1, 1'b0, 4'd2, 32'd200, 32'h12};
        vecs[4] = '{4'b0000, 32'h0,  32'd204, 1'b1, 1'b1, 4'd1, 1'b0, 4'd3, 32'd200, 32'h13};
        vecs[5] = '{4'b0000, 32'h0,  32'd205, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,   32'h0};
        vecs[6] = '{4'b0100, 32'h53, 32'd100, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,   32'h0};
        vecs[7] = '{4'b0000, 32'h0,  32'd101, 1'b1, 1'b1, 4'd1, 1'b0, 4'd2, 32'd100, 32'h55};
        vecs[8] = '{4'b0000, 32'h0,  32'd102, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,   32'h0};

        rst = 1'b0;
        send = '0;
        data = '0;
        global_clock = '0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", 128'(out_valid), 128'(0));
        chk("reset_level", 128'(level), 128'(0));
        chk("reset_ovf", 128'(overflow), 128'(0));
        rst = 1'b1;

        for (int r = 0; r < 9; r++) begin
            step(vecs[r].s, vecs[r].base, vecs[r].gc, vecs[r].rdy, 1'b0);
            chk("vec_valid", 128'(out_valid), 128'(vecs[r].exp_valid));
            chk("vec_level", 128'(level), 128'(vecs[r].exp_level));
            chk("vec_ovf", 128'(overflow), 128'(vecs[r].exp_ovf));
            if (vecs[r].exp_valid) begin
                chk("vec_src", 128'(out_event.src), 128'(vecs[r].exp_src));
                chk("vec_ts", 128'(out_event.ts), 128'(vecs[r].exp_ts));
                chk("vec_value", 128'(out_event.value), 128'(vecs[r].exp_val));
            end
        end

        // Back-pressure: 12 back-to-back sends on source 0 with the consumer stalled.
        for (int k = 0; k < 12; k++) step(4'b0001, W'(k), W'(1000 + k), 1'b0, 1'b0);
        chk("bp_level_full", 128'(level), 128'(8));
        chk("bp_overflow", 128'(overflow), 128'(1));
        for (int k = 0; k < 9; k++) begin
            chk("bp_drain_valid", 128'(out_valid), 128'(1));
            chk("bp_drain_value", 128'(out_event.value), 128'(k));
            chk("bp_drain_ts", 128'(out_event.ts), 128'(1000 + k));
            step(4'b0000, 32'h0, 32'd0, 1'b1, 1'b0);
        end
        chk("bp_empty", 128'(out_valid), 128'(0));
        step(4'b0000, 32'h0, 32'd0, 1'b1, 1'b1);
        chk("bp_clr_ovf", 128'(overflow), 128'(0));

        // Reload of source 1 in the very cycle its slot is granted.
        step(4'b0010, 32'hA0, 32'd2000, 1'b1, 1'b0);
        step(4'b0010, 32'hB0, 32'd2001, 1'b1, 1'b0);
        chk("reload_first", 128'(out_event.value), 128'(32'hA1));
        step(4'b0000, 32'h0, 32'd2002, 1'b1, 1'b0);
        chk("reload_second_valid", 128'(out_valid), 128'(1));
        chk("reload_second", 128'(out_event.value), 128'(32'hB1));
        step(4'b0000, 32'h0, 32'd2003, 1'b1, 1'b0);
        chk("reload_done", 128'(out_valid), 128'(0));
        chk("reload_ovf", 128'(overflow), 128'(0));

        // Reset mid-stream with five events queued.
        for (int k = 0; k < 5; k++) step(4'b0001, W'(k), W'(2500 + k), 1'b0, 1'b0);
        step(4'b0000, 32'h0, 32'd2505, 1'b0, 1'b0);
        chk("mid_level_before", 128'(level), 128'(5));
        rst = 1'b0;
        #1;
        chk("mid_reset_level", 128'(level), 128'(0));
        chk("mid_reset_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        step(4'b1000, 32'h77, 32'd3000, 1'b1, 1'b0);
        chk("post_reset_t1", 128'(out_valid), 128'(0));
        step(4'b0000, 32'h0, 32'd3001, 1'b1, 1'b0);
        chk("post_reset_t2", 128'(out_valid), 128'(1));
        chk("post_reset_event", 128'(out_event), 128'({4'd3, 32'd3000, 32'h7A}));
        step(4'b0000, 32'h0, 32'd3002, 1'b1, 1'b0);
        chk("post_reset_gone", 128'(out_valid), 128'(0));

        // Random traffic alternating between stalled and flowing consumer phases.
        for (int c = 0; c < 800; c++) begin
            logic rdy;
            if ((c % 64) < 32) rdy = 1'($urandom_range(0, 1));
            else               rdy = ($urandom_range(0, 4) != 0);
            step(N'($urandom) & N'($urandom), W'($urandom), W'($urandom), rdy,
                 ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
